scsp_eg: RTL and testbench

Per-slot envelope generator stage of the SCSP slot pipeline. It processes one slot per enabled clock, time-multiplexed over 32 slots. For each slot it:
- applies key-on/key-off events arriving from the upstream pipe (`OPPipe_t`);
- advances the ADSR state machine (`EGState_t`);
- stores the 10-bit attenuation (`OP4State_t.EVOL`) and state per slot.

The registered result feeds the downstream level/mix stage, one slot per CE.

---
 rtl/scsp_eg.sv | 182 ++++++++++++++++++
 tb/tb_scsp_eg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/scsp_eg.sv
`default_nettype none
// ============================================================================
// Module   : scsp_eg
// Brief    : Per-slot ADSR envelope generator, 32 time-multiplexed slots with
//            rate gating from a global sample counter.
// Revision : 1.0 - initial release
// ============================================================================
module scsp_eg #(
    parameter int SLOTS = 32,
    parameter int CNT_W = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic [4:0] SLOT_IN,
    input  logic       KON,
    input  logic       KOFF,
    input  logic [4:0] AR,
    input  logic [4:0] D1R,
    input  logic [4:0] D2R,
    input  logic [4:0] RR,
    input  logic [4:0] DL,
    input  logic [3:0] KRS,
    input  logic [3:0] OCT,
    input  logic       HO,
    output logic [9:0] EVOL_OUT,
    output logic [4:0] ST_OUT,
    output logic [4:0] SLOT_OUT,
    output logic       VALID_OUT
);

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ATTACK  = 5'b00010,
        ST_DECAY1  = 5'b00100,
        ST_DECAY2  = 5'b01000,
        ST_RELEASE = 5'b10000
    } eg_state_t;

    localparam logic [9:0] c_evol_max = 10'h3FF;

    logic [9:0]       r_evol [SLOTS];
    eg_state_t        r_st   [SLOTS];
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_evol_out;
    eg_state_t        r_st_out;
    logic [4:0]       r_slot_out;
    logic             r_valid_out;

    logic [9:0]        w_cur_evol;
    eg_state_t         w_cur_st;
    logic [4:0]        w_rate;
    logic signed [7:0] w_eff_raw;
    logic [5:0]        w_eff;
    logic [3:0]        w_shift;
    logic [CNT_W-1:0]  w_mask;
    logic              w_step;
    logic [3:0]        w_inc;
    logic [10:0]       w_dec;
    logic [10:0]       w_add;
    logic [9:0]        w_evol_sub;
    logic [9:0]        w_evol_add;
    logic [9:0]        w_nxt_evol;
    eg_state_t         w_nxt_st;

    // Rate selection, key scaling and step gating for the slot in flight
    always_comb begin
        w_cur_evol = r_evol[SLOT_IN];
        w_cur_st   = r_st[SLOT_IN];
        case (w_cur_st)
            ST_ATTACK:  w_rate = AR;
            ST_DECAY1:  w_rate = D1R;
            ST_DECAY2:  w_rate = D2R;
            ST_RELEASE: w_rate = RR;
            default:    w_rate = 5'd0;
        endcase

        w_eff_raw = $signed({2'b00, w_rate, 1'b0});
        if (KRS != 4'hF)
            w_eff_raw = w_eff_raw + $signed({4'b0000, KRS}) + $signed({{4{OCT[3]}}, OCT});

        if (w_rate == 5'd0 || w_eff_raw < 0)
            w_eff = 6'd0;
        else if (w_eff_raw > 8'sd63)
            w_eff = 6'd63;
        else
            w_eff = w_eff_raw[5:0];

        w_shift = 4'd12 - w_eff[5:2];
        w_mask  = (CNT_W'(1) << w_shift) - CNT_W'(1);
        w_step  = 1'b0;
        w_inc   = 4'd1;
        if (w_eff >= 6'd48) begin
            w_step = 1'b1;
            w_inc  = 4'd1 << (w_eff[5:2] - 4'd12);
        end else if (w_eff >= 6'd2) begin
            w_step = ((r_cnt & w_mask) == '0);
        end
    end

    // Saturating envelope arithmetic in 11 bits
    always_comb begin
        w_dec      = ({5'd0, w_cur_evol[9:4]} + 11'd1) * {7'd0, w_inc};
        w_add      = {1'b0, w_cur_evol} + {7'd0, w_inc};
        w_evol_sub = (w_dec > {1'b0, w_cur_evol}) ? 10'd0 : 10'(({1'b0, w_cur_evol} - w_dec));
        w_evol_add = w_add[10] ? c_evol_max : w_add[9:0];
    end

    always_comb begin
        w_nxt_evol = w_cur_evol;
        w_nxt_st   = w_cur_st;
        if (KON) begin
            w_nxt_evol = HO ? 10'd0 : c_evol_max;
            w_nxt_st   = HO ? ST_DECAY1 : ST_ATTACK;
        end else if (KOFF && w_cur_st != ST_IDLE) begin
            w_nxt_st = ST_RELEASE;
        end else begin
            case (w_cur_st)
                ST_ATTACK: begin
                    if (w_eff >= 6'd62)
                        w_nxt_evol = 10'd0;
                    else if (w_step)
                        w_nxt_evol = w_evol_sub;
                    if (w_nxt_evol == 10'd0)
                        w_nxt_st = ST_DECAY1;
                end
                ST_DECAY1: begin
                    if (w_step)
                        w_nxt_evol = w_evol_add;
                    if (w_nxt_evol[9:5] >= DL)
                        w_nxt_st = ST_DECAY2;
                end
                ST_DECAY2: begin
                    if (w_step)
                        w_nxt_evol = w_evol_add;
                end
                ST_RELEASE: begin
                    if (w_step)
                        w_nxt_evol = w_evol_add;
                    if (w_nxt_evol == c_evol_max)
                        w_nxt_st = ST_IDLE;
                end
                default: begin
                    w_nxt_evol = c_evol_max;
                    w_nxt_st   = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_evol[i] <= c_evol_max;
                r_st[i]   <= ST_IDLE;
            end
            r_cnt       <= '0;
            r_evol_out  <= c_evol_max;
            r_st_out    <= ST_IDLE;
            r_slot_out  <= 5'd0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= CE;
            if (CE) begin
                r_evol[SLOT_IN] <= w_nxt_evol;
                r_st[SLOT_IN]   <= w_nxt_st;
                r_evol_out      <= w_nxt_evol;
                r_st_out        <= w_nxt_st;
                r_slot_out      <= SLOT_IN;
                if (SLOT_IN == 5'(SLOTS - 1))
                    r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign EVOL_OUT  = r_evol_out;
    assign ST_OUT    = r_st_out;
    assign SLOT_OUT  = r_slot_out;
    assign VALID_OUT = r_valid_out;

endmodule
`default_nettype wire

// File: tb/tb_scsp_eg.sv
`default_nettype none
// ============================================================================
// Module   : tb_scsp_eg
// Brief    : Scoreboard bench for scsp_eg using directed slot passes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scsp_eg;

    localparam logic [4:0] c_idle = 5'b00001;
    localparam logic [4:0] c_atk  = 5'b00010;
    localparam logic [4:0] c_d1   = 5'b00100;
    localparam logic [4:0] c_d2   = 5'b01000;
    localparam logic [4:0] c_rel  = 5'b10000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [4:0] slot_in;
    logic       kon, koff;
    logic [4:0] ar, d1r, d2r, rr, dl;
    logic [3:0] krs, oct;
    logic       ho;
    logic [9:0] evol_out;
    logic [4:0] st_out, slot_out;
    logic       valid_out;

    typedef struct {
        logic [4:0] slot;
        logic [9:0] evol;
        logic [4:0] st;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    scsp_eg #(.SLOTS(32), .CNT_W(15)) dut (
        .CLK(clk), .RST(rst), .CE(ce), .SLOT_IN(slot_in),
        .KON(kon), .KOFF(koff),
        .AR(ar), .D1R(d1r), .D2R(d2r), .RR(rr), .DL(dl),
        .KRS(krs), .OCT(oct), .HO(ho),
        .EVOL_OUT(evol_out), .ST_OUT(st_out), .SLOT_OUT(slot_out), .VALID_OUT(valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One CE pass of a slot; expected result queued for the monitor
    task automatic pass(input logic [4:0] s, input logic k_on, input logic k_off,
                        input logic [9:0] e_evol, input logic [4:0] e_st);
        exp_t e;
        slot_in = s;
        kon     = k_on;
        koff    = k_off;
        ce      = 1'b1;
        e.slot  = s;
        e.evol  = e_evol;
        e.st    = e_st;
        q.push_back(e);
        @(posedge clk);
        #1;
        ce   = 1'b0;
        kon  = 1'b0;
        koff = 1'b0;
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: slot %0d produced with empty scoreboard", slot_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("slot_out", 16'(slot_out), 16'(e.slot));
                check("evol_out", 16'(evol_out), 16'(e.evol));
                check("st_out",   16'(st_out),   16'(e.st));
            end
        end
    end

    initial begin
        logic       in_d2;
        logic [9:0] ev;
        rst = 1'b1; ce = 1'b0; slot_in = 5'd0; kon = 1'b0; koff = 1'b0;
        ar = 5'd0; d1r = 5'd0; d2r = 5'd0; rr = 5'd0; dl = 5'd0;
        krs = 4'hF; oct = 4'h0; ho = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_evol",  16'(evol_out),  16'h3FF);
        check("reset_st",    16'(st_out),    16'(c_idle));
        check("reset_slot",  16'(slot_out),  16'h0);
        check("reset_valid", 16'(valid_out), 16'h0);
        rst = 1'b0;

        for (int s = 0; s < 32; s++)
            pass(5'(s), 1'b0, 1'b0, 10'h3FF, c_idle);

        // Instant attack then decay-1 into decay-2 at DL=1
        ar = 5'd31;
        pass(5'd3, 1'b1, 1'b0, 10'h3FF, c_atk);
        pass(5'd3, 1'b0, 1'b0, 10'h000, c_d1);
        d1r = 5'd31; dl = 5'd1;
        pass(5'd3, 1'b0, 1'b0, 10'd8,  c_d1);
        pass(5'd3, 1'b0, 1'b0, 10'd16, c_d1);
        pass(5'd3, 1'b0, 1'b0, 10'd24, c_d1);
        pass(5'd3, 1'b0, 1'b0, 10'd32, c_d2);

        // Gated attack: CNT=1 blocks the step, CNT=4 allows it
        ar = 5'd20;
        pass(5'd3, 1'b1, 1'b0, 10'h3FF, c_atk);
        pass(5'd3, 1'b0, 1'b0, 10'h3FF, c_atk);
        repeat (3) pass(5'd31, 1'b0, 1'b0, 10'h3FF, c_idle);
        pass(5'd3, 1'b0, 1'b0, 10'h3BF, c_atk);

        // Hold key-on, inc=4 decay up to 0x3FC, then release
        d1r = 5'd28; d2r = 5'd28; dl = 5'd31; ho = 1'b1;
        pass(5'd5, 1'b1, 1'b0, 10'h000, c_d1);
        ho = 1'b0;
        in_d2 = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            ev = 10'(4 * k);
            if (ev[9:5] >= 5'd31)
                in_d2 = 1'b1;
            pass(5'd5, 1'b0, 1'b0, ev, in_d2 ? c_d2 : c_d1);
        end
        rr = 5'd31;
        pass(5'd5, 1'b0, 1'b1, 10'h3FC, c_rel);
        pass(5'd5, 1'b0, 1'b0, 10'h3FF, c_idle);
        pass(5'd5, 1'b0, 1'b1, 10'h3FF, c_idle);

        // Effective-rate clamping at both ends
        ar = 5'd4; krs = 4'h0; oct = 4'h8;
        pass(5'd9, 1'b1, 1'b0, 10'h3FF, c_atk);
        pass(5'd9, 1'b0, 1'b0, 10'h3FF, c_atk);
        ar = 5'd31; krs = 4'hE; oct = 4'h7;
        pass(5'd9, 1'b0, 1'b0, 10'h000, c_d1);
        krs = 4'hF; oct = 4'h0;

        // KON beats KOFF, then reset mid-release
        pass(5'd7, 1'b1, 1'b1, 10'h3FF, c_atk);
        pass(5'd7, 1'b0, 1'b0, 10'h000, c_d1);
        pass(5'd7, 1'b0, 1'b1, 10'h000, c_rel);
        rst = 1'b1; ce = 1'b1; slot_in = 5'd7; kon = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_evol",  16'(evol_out),  16'h3FF);
        check("midrst_st",    16'(st_out),    16'(c_idle));
        check("midrst_slot",  16'(slot_out),  16'h0);
        check("midrst_valid", 16'(valid_out), 16'h0);
        rst = 1'b0; ce = 1'b0; kon = 1'b0;
        pass(5'd7, 1'b0, 1'b0, 10'h3FF, c_idle);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 16'(q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
